// File: rtl/sound_pkg.sv
// Shared types, widths and the note ROM for the sound-event arbiter.
package sound_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned HP_W    = 16;
  localparam int unsigned FR_W    = 4;
  localparam int unsigned GAP_W   = 8;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} snd_state_t;

  typedef struct packed {
    logic [HP_W-1:0] half_period;
    logic [FR_W-1:0] frames;
  } note_t;

  // Note ROM: frames==0 marks the end of a sequence.
  function automatic note_t get_note(input logic [1:0] id, input logic [1:0] idx);
    note_t n;
    n = '0;
    case ({id, idx})
      4'b00_00: n = {16'd40000, 4'd8};
      4'b00_01: n = {16'd50000, 4'd8};
      4'b00_10: n = {16'd60000, 4'd8};
      4'b01_00: n = {16'd20000, 4'd4};
      4'b01_01: n = {16'd15000, 4'd4};
      4'b01_10: n = {16'd12500, 4'd6};
      4'b10_00: n = {16'd12500, 4'd3};
      4'b10_01: n = {16'd10000, 4'd3};
      4'b11_00: n = {16'd25000, 4'd2};
      default:  n = '0;
    endcase
    return n;
  endfunction

  // Lowest set index wins (index 0 = highest priority).
  function automatic logic [ID_W-1:0] first_set(input logic [NUM_REQ-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sound_event_arbiter_tone_gen.sv
// Square-wave generator: toggles wave every half_period cycles; 0 = rest.
module tone_gen
  import sound_pkg::*;
(
  input  logic            clk,
  input  logic            resetN,
  input  logic            clear,
  input  logic [HP_W-1:0] half_period,
  output logic            wave
);

  logic [HP_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt_q <= '0;
      wave  <= 1'b0;
    end else if (clear || half_period == '0) begin
      cnt_q <= '0;
      wave  <= 1'b0;
    end else if (cnt_q == half_period - HP_W'(1)) begin
      cnt_q <= '0;
      wave  <= ~wave;
    end else begin
      cnt_q <= cnt_q + HP_W'(1);
    end
  end

endmodule

// File: rtl/sound_event_arbiter.sv
// Fixed-priority, pre-emptive arbiter sharing one buzzer among game sound events.
module sound_event_arbiter
  import sound_pkg::*;
#(
  parameter int unsigned GAP_FRAMES = 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic               buzzer,
  output logic               busy,
  output logic [ID_W-1:0]    active_id
);

  snd_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [1:0]         idx_q, idx_d;
  note_t              note_q, note_d, next_note;
  logic [FR_W-1:0]    fl_q, fl_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               busy_q;
  logic               grant, advance, tone_clear;
  logic [NUM_REQ-1:0] drop_mask, clr_mask, higher;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      pend_q  <= '0;
      id_q    <= '0;
      idx_q   <= '0;
      note_q  <= '0;
      fl_q    <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      note_q  <= note_d;
      fl_q    <= fl_d;
      gap_q   <= gap_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    id_d      = id_q;
    idx_d     = idx_q;
    note_d    = note_q;
    fl_d      = fl_q;
    gap_d     = gap_q;
    grant     = 1'b0;
    advance   = 1'b0;
    next_note = get_note(id_q, 2'(idx_q + 2'd1));
    higher    = pend_q & NUM_REQ'((NUM_REQ'(1) << id_q) - NUM_REQ'(1));
    drop_mask = (state_q != IDLE) ? NUM_REQ'(NUM_REQ'(1) << id_q) : '0;
    clr_mask  = '0;

    if (!enable) begin
      state_d = IDLE;
      pend_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q != '0) begin
            grant   = 1'b1;
            id_d    = first_set(pend_q);
            state_d = LOAD;
          end
        end
        LOAD: begin
          idx_d   = '0;
          note_d  = get_note(id_q, 2'd0);
          fl_d    = note_d.frames;
          state_d = PLAY;
        end
        PLAY: begin
          if (higher != '0) begin
            grant   = 1'b1;
            id_d    = first_set(higher);
            state_d = LOAD;
          end else if (startOfFrame) begin
            if (fl_q <= FR_W'(1)) begin
              if (idx_q == 2'd3 || next_note.frames == '0) begin
                gap_d   = '0;
                state_d = GAP;
              end else begin
                advance = 1'b1;
                idx_d   = 2'(idx_q + 2'd1);
                note_d  = next_note;
                fl_d    = next_note.frames;
              end
            end else begin
              fl_d = FR_W'(fl_q - FR_W'(1));
            end
          end
        end
        GAP: begin
          if (higher != '0) begin
            grant   = 1'b1;
            id_d    = first_set(higher);
            state_d = LOAD;
          end else if (startOfFrame) begin
            if (gap_q == GAP_W'(GAP_FRAMES - 1)) state_d = IDLE;
            else gap_d = GAP_W'(gap_q + GAP_W'(1));
          end
        end
        default: state_d = IDLE;
      endcase

      // New requests beat the grant clear; repeats of the active event are dropped.
      if (grant) clr_mask = NUM_REQ'(NUM_REQ'(1) << id_d);
      pend_d = (pend_q & ~clr_mask) | (req & ~drop_mask);
    end
  end

  // Tone restarts from silence on every note entry and stays silent outside PLAY.
  assign tone_clear = (state_q != PLAY) || (state_d != PLAY) || advance;

  tone_gen u_tone (
    .clk         (clk),
    .resetN      (resetN),
    .clear       (tone_clear),
    .half_period (note_q.half_period),
    .wave        (buzzer)
  );

  assign busy      = busy_q;
  assign active_id = id_q;

endmodule

// File: tb/tb_sound_event_arbiter.sv
// Directed, table-driven bench for sound_event_arbiter.
module tb_sound_event_arbiter;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       enable;
  logic [3:0] req;
  logic       buzzer;
  logic       busy;
  logic [1:0] active_id;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic       exp_busy;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[10];

  sound_event_arbiter #(.GAP_FRAMES(1)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .enable       (enable),
    .req          (req),
    .buzzer       (buzzer),
    .busy         (busy),
    .active_id    (active_id)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  task automatic sofs(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic mute();
    enable = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  // Cycles until buzzer changes from its current level, bounded.
  task automatic measure(input string nm, input int exp);
    logic b0;
    int   n;
    b0 = buzzer;
    n  = 0;
    while (buzzer === b0 && n < exp + 100) begin
      tick();
      n++;
    end
    check(nm, n, exp);
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[1] = '{1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[2] = '{1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[3] = '{1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[4] = '{1'b1, 4'b1010, 1'b1, 2'd1};
    vecs[5] = '{1'b1, 4'b1100, 1'b1, 2'd2};
    vecs[6] = '{1'b1, 4'b1111, 1'b1, 2'd0};
    vecs[7] = '{1'b1, 4'b0110, 1'b1, 2'd1};
    vecs[8] = '{1'b0, 4'b0100, 1'b0, 2'd0};
    vecs[9] = '{1'b0, 4'b1111, 1'b0, 2'd0};

    resetN = 1'b0;
    enable = 1'b1;
    startOfFrame = 1'b0;
    req = '0;

    // Reset with random request noise
    for (int i = 0; i < 2; i++) begin
      req = 4'($urandom);
      tick();
    end
    req = '0;
    check("rst_buzzer", buzzer, 0);
    check("rst_busy", busy, 0);
    check("rst_id", active_id, 0);
    resetN = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("rst_idle_after", busy, 0);

    // Priority / latency / enable table
    for (int i = 0; i < 10; i++) begin
      mute();
      enable = vecs[i].en;
      pulse(vecs[i].req);
      check($sformatf("vec%0d_busy_n1", i), busy, 0);
      tick();
      check($sformatf("vec%0d_busy_n2", i), busy, vecs[i].exp_busy);
      if (vecs[i].exp_busy) check($sformatf("vec%0d_id", i), active_id, vecs[i].exp_id);
      enable = 1'b1;
      tick();
      tick();
      check($sformatf("vec%0d_busy_later", i), busy, vecs[i].exp_busy);
    end
    mute();
    tick();

    // Diamond sequence and tone periods
    pulse(4'b0100);
    check("dia_busy_n1", busy, 0);
    tick();
    check("dia_busy_n2", busy, 1);
    check("dia_id", active_id, 2);
    measure("dia_hp0", 12501);
    sofs(2);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("dia_adv_buzzer", buzzer, 0);
    measure("dia_hp1", 10000);
    sofs(3);
    check("dia_gap_busy", busy, 1);
    check("dia_gap_buzzer", buzzer, 0);
    sofs(1);
    check("dia_done_busy", busy, 0);

    // Simultaneous gold + shot
    pulse(4'b1010);
    tick();
    check("sim_id_gold", active_id, 1);
    tick();
    sofs(14);
    check("sim_gold_gap", busy, 1);
    check("sim_gold_gap_id", active_id, 1);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("sim_gap_idle", busy, 0);
    tick();
    check("sim_shot_busy", busy, 1);
    check("sim_shot_id", active_id, 3);
    tick();
    sofs(2);
    check("sim_shot_gap", busy, 1);
    sofs(1);
    check("sim_shot_done", busy, 0);

    // Pre-emption of shot by died
    pulse(4'b1000);
    tick();
    check("pre_shot_id", active_id, 3);
    tick();
    for (int i = 0; i < 10; i++) tick();
    pulse(4'b0001);
    tick();
    check("pre_died_id", active_id, 0);
    check("pre_busy", busy, 1);
    check("pre_buzzer0", buzzer, 0);
    measure("pre_hp0", 40001);
    sofs(24);
    check("pre_gap", busy, 1);
    sofs(1);
    check("pre_done", busy, 0);
    for (int i = 0; i < 4; i++) tick();
    check("pre_no_resume", busy, 0);

    // Coalescing repeated diamond requests
    pulse(4'b0100);
    tick();
    tick();
    pulse(4'b0100);
    tick();
    pulse(4'b0100);
    pulse(4'b0100);
    sofs(6);
    check("coa_gap", busy, 1);
    sofs(1);
    check("coa_done", busy, 0);
    for (int i = 0; i < 4; i++) tick();
    check("coa_no_replay", busy, 0);

    // Mute (m=0) and reset (m=1) during gold, then fresh replay
    for (int m = 0; m < 2; m++) begin
      pulse(4'b0010);
      tick();
      check($sformatf("mute%0d_gold_id", m), active_id, 1);
      tick();
      sofs(2);
      pulse(4'b1000);
      if (m == 0) enable = 1'b0;
      else resetN = 1'b0;
      tick();
      check($sformatf("mute%0d_buzzer", m), buzzer, 0);
      check($sformatf("mute%0d_busy", m), busy, 0);
      if (m == 1) check("mute1_id", active_id, 0);
      enable = 1'b1;
      resetN = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check($sformatf("mute%0d_pend_clear", m), busy, 0);
      pulse(4'b0010);
      tick();
      check($sformatf("mute%0d_replay_id", m), active_id, 1);
      tick();
      sofs(14);
      check($sformatf("mute%0d_replay_gap", m), busy, 1);
      sofs(1);
      check($sformatf("mute%0d_replay_done", m), busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
